// File: rtl/mem_pkg.sv
// Shared constants for the MEM-stage data access unit: funct3 encodings and FSM states.
package mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Combinational load lane select and sign/zero extension of a fetched word.
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign shifted  = word >> {off, 3'b000};
  assign byte_sel = shifted[7:0];
  // Halfwords pick their lane from off[1] only; off[0] never shifts a half.
  assign half_sel = off[1] ? word[31:16] : word[15:0];

  always_comb begin
    result = word;
    case (funct3)
      F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   result = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  result = {24'h0, byte_sel};
      F3_LHU:  result = {16'h0, half_sel};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store bus master with stall handshake; IDLE -> (WAIT) -> DONE -> IDLE.
// Optional macro MEM_MISALIGN_TRAP_EN flags misaligned half/word accesses instead of issuing them.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       ALUResultM,
  input  logic [31:0]       WriteDataM,
  input  logic              MemReadM,
  input  logic              MemWriteM,
  input  logic [2:0]        funct3M,
  output logic [31:0]       ReadDataM,
  output logic              StallM,
  output logic              MisalignM,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [1:0]        dbg_state
);

  // Handshake: mem_req stays high with stable address/strobes/data until the
  // cycle mem_ready is seen high; that cycle completes the access and
  // mem_rdata is sampled. mem_ready is ignored whenever mem_req is low.

  mem_state_t  state, state_nxt;
  logic [31:0] rdata_q;
  logic [31:0] ext_data;
  logic [1:0]  off;
  logic        access;
  logic        misalign;
  logic        req, stall;
  logic [3:0]  strb;
  logic [31:0] wdata;
  logic [ADDR_W-1:0] addr_ext;

  assign off      = ALUResultM[1:0];
  assign access   = MemReadM | MemWriteM;
  assign addr_ext = ADDR_W'(ALUResultM);

`ifdef MEM_MISALIGN_TRAP_EN
  always_comb begin
    misalign = 1'b0;
    if (access) begin
      if (MemWriteM)
        misalign = ((funct3M == F3_SH) && off[0]) || ((funct3M == F3_SW) && (off != 2'b00));
      else
        misalign = (((funct3M == F3_LH) || (funct3M == F3_LHU)) && off[0]) ||
                   ((funct3M == F3_LW) && (off != 2'b00));
    end
  end
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        if (access && !misalign) begin
          req       = 1'b1;
          stall     = 1'b1;
          state_nxt = mem_ready ? DONE : WAIT;
        end
      end
      WAIT: begin
        req   = 1'b1;
        stall = 1'b1;
        if (mem_ready) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rdata_q <= 32'h0;
    end else begin
      state <= state_nxt;
      if (req && mem_ready) rdata_q <= mem_rdata;
    end
  end

  // Store lane generation; size comes from funct3[1:0] (byte, half, else word).
  always_comb begin
    strb  = 4'b1111;
    wdata = WriteDataM;
    case (funct3M[1:0])
      2'b00: begin
        strb  = 4'b0001 << off;
        wdata = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        strb  = 4'b0011 << {off[1], 1'b0};
        wdata = {2{WriteDataM[15:0]}};
      end
      default: begin
        strb  = 4'b1111;
        wdata = WriteDataM;
      end
    endcase
  end

  load_extend u_load_extend (
    .word   (rdata_q),
    .off    (off),
    .funct3 (funct3M),
    .result (ext_data)
  );

  assign mem_req   = req & ~rst;
  assign StallM    = stall & ~rst;
  assign mem_we    = mem_req & MemWriteM;
  assign mem_addr  = mem_req ? {addr_ext[ADDR_W-1:2], 2'b00} : '0;
  assign mem_wstrb = mem_we ? strb : 4'b0000;
  assign mem_wdata = mem_we ? wdata : 32'h0;
  assign MisalignM = misalign & ~rst;
  assign ReadDataM = (!rst && (state == DONE) && !MemWriteM) ? ext_data : 32'h0;
  assign dbg_state = state;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, reset/misalign sequences, random loads/stores vs. a model.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ALUResultM, WriteDataM;
  logic        MemReadM, MemWriteM;
  logic [2:0]  funct3M;
  logic [31:0] ReadDataM;
  logic        StallM, MisalignM;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ready;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM), .funct3M(funct3M),
    .ReadDataM(ReadDataM), .StallM(StallM), .MisalignM(MisalignM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .dbg_state(dbg_state)
  );

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    int          waits;
    logic [31:0] exp_rd;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wd;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain arithmetic on the architectural load/store rules.
  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
    int unsigned off, b, h;
    off = addr % 4;
    b = (word / (1 << (8 * off))) % 256;
    h = (addr % 4 >= 2) ? (word / 65536) : (word % 65536);
    case (f3)
      3'b000:  return (b >= 128) ? 32'(b + 32'hFFFF_FF00) : 32'(b);
      3'b001:  return (h >= 32768) ? 32'(h + 32'hFFFF_0000) : 32'(h);
      3'b100:  return 32'(b);
      3'b101:  return 32'(h);
      default: return word;
    endcase
  endfunction

  function automatic logic [3:0] model_strb(input logic [2:0] f3, input logic [31:0] addr);
    case (f3)
      3'b000:  return 4'(1 << (addr % 4));
      3'b001:  return (addr % 4 >= 2) ? 4'd12 : 4'd3;
      default: return 4'd15;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'b000:  return (d % 256) * 32'h0101_0101;
      3'b001:  return (d % 65536) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  task automatic set_idle();
    MemReadM = 1'b0; MemWriteM = 1'b0; funct3M = 3'b000;
    ALUResultM = $urandom; WriteDataM = $urandom;
  endtask

  // Idle cycles with noise on mem_ready: the unit must stay quiet.
  task automatic idle_cycles(input int n);
    set_idle();
    for (int i = 0; i < n; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      @(negedge clk);
      chk("idle_req", {31'h0, mem_req}, 32'h0);
      chk("idle_stall", {31'h0, StallM}, 32'h0);
      chk("idle_rdata", ReadDataM, 32'h0);
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
  endtask

  // Entered #1 after a posedge; returns #1 after the posedge that ends DONE.
  task automatic run_txn(input vec_t v);
    int  stalls;
    bit  done;
    logic [31:0] exp_addr;
    exp_addr = v.addr - (v.addr % 4);
    MemReadM = ~v.st; MemWriteM = v.st; funct3M = v.f3;
    ALUResultM = v.addr; WriteDataM = v.wd;
    stalls = 0; done = 0;
    for (int c = 0; c < v.waits + 8 && !done; c++) begin
      mem_ready = (c == v.waits);
      mem_rdata = (c == v.waits) ? v.rd : $urandom;
      @(negedge clk);
      if (StallM) begin
        stalls++;
        chk("busy_req", {31'h0, mem_req}, 32'h1);
        chk("busy_we", {31'h0, mem_we}, {31'h0, v.st});
        chk("busy_addr", mem_addr, exp_addr);
        chk("busy_wstrb", {28'h0, mem_wstrb}, v.st ? {28'h0, v.exp_strb} : 32'h0);
        chk("busy_wdata", mem_wdata, v.st ? v.exp_wd : 32'h0);
        chk("busy_rdata", ReadDataM, 32'h0);
      end else begin
        done = 1;
        chk("done_rdata", ReadDataM, v.st ? 32'h0 : v.exp_rd);
        chk("done_req", {31'h0, mem_req}, 32'h0);
        chk("stall_cycles", stalls, v.waits + 1);
        chk("done_state", {30'h0, dbg_state}, {30'h0, DONE});
      end
      @(posedge clk); #1;
    end
    if (!done) chk("txn_timeout", 32'h1, 32'h0);
    mem_ready = 1'b0;
  endtask

  function automatic vec_t mk(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [31:0] rd, input int waits,
                              input logic [31:0] exp_rd, input logic [3:0] exp_strb,
                              input logic [31:0] exp_wd);
    vec_t v;
    v.st = st; v.f3 = f3; v.addr = addr; v.wd = wd; v.rd = rd; v.waits = waits;
    v.exp_rd = exp_rd; v.exp_strb = exp_strb; v.exp_wd = exp_wd;
    return v;
  endfunction

  initial begin
    vec_t v;
    // Directed table; back-to-back LW 0x0 / LW 0x4 are consecutive entries.
    vecs.push_back(mk(0, F3_LW,  32'h100, 0, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 0, 0));
    vecs.push_back(mk(0, F3_LB,  32'h103, 0, 32'h8011_2233, 2, 32'hFFFF_FF80, 0, 0));
    vecs.push_back(mk(0, F3_LBU, 32'h103, 0, 32'h8011_2233, 1, 32'h0000_0080, 0, 0));
    vecs.push_back(mk(1, F3_SH,  32'h102, 32'h0000_ABCD, 0, 0, 0, 4'b1100, 32'hABCD_ABCD));
    vecs.push_back(mk(0, F3_LW,  32'h0,   0, 32'h1111_1111, 0, 32'h1111_1111, 0, 0));
    vecs.push_back(mk(0, F3_LW,  32'h4,   0, 32'h2222_2222, 1, 32'h2222_2222, 0, 0));
    vecs.push_back(mk(1, F3_SB,  32'h101, 32'h1234_565A, 0, 1, 0, 4'b0010, 32'h5A5A_5A5A));
    vecs.push_back(mk(0, F3_LHU, 32'h202, 0, 32'h8001_7FFF, 0, 32'h0000_8001, 0, 0));
    vecs.push_back(mk(0, F3_LH,  32'h200, 0, 32'h8001_7FFF, 0, 32'h0000_7FFF, 0, 0));
    vecs.push_back(mk(0, F3_LH,  32'h202, 0, 32'h8001_7FFF, 3, 32'hFFFF_8001, 0, 0));
    vecs.push_back(mk(1, F3_SW,  32'h8,   32'h1234_5678, 0, 2, 0, 4'b1111, 32'h1234_5678));
    vecs.push_back(mk(0, 3'b110, 32'h10,  0, 32'hCAFE_F00D, 0, 32'hCAFE_F00D, 0, 0));

    // Reset cycle with an access and mem_ready asserted: every output is 0.
    rst = 1'b1;
    MemReadM = 1'b1; MemWriteM = 1'b1; funct3M = F3_SW;
    ALUResultM = 32'h104; WriteDataM = 32'hFFFF_FFFF;
    mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("rst_req", {31'h0, mem_req}, 32'h0);
    chk("rst_stall", {31'h0, StallM}, 32'h0);
    chk("rst_we", {31'h0, mem_we}, 32'h0);
    chk("rst_wstrb", {28'h0, mem_wstrb}, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_rdata", ReadDataM, 32'h0);
    chk("rst_misalign", {31'h0, MisalignM}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    mem_ready = 1'b0;
    idle_cycles(2);
    @(negedge clk);
    chk("post_rst_state", {30'h0, dbg_state}, {30'h0, IDLE});
    @(posedge clk); #1;

    foreach (vecs[i]) run_txn(vecs[i]);
    idle_cycles(2);

    // Reset mid-WAIT, then a late mem_ready pulse that must be ignored.
    MemReadM = 1'b1; MemWriteM = 1'b0; funct3M = F3_LW; ALUResultM = 32'h300;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("wait_state", {30'h0, dbg_state}, {30'h0, WAIT});
    chk("wait_stall", {31'h0, StallM}, 32'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_wait_stall", {31'h0, StallM}, 32'h0);
    chk("rst_wait_req", {31'h0, mem_req}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    set_idle();
    mem_ready = 1'b1; mem_rdata = 32'h5555_5555;
    @(negedge clk);
    chk("abandon_state", {30'h0, dbg_state}, {30'h0, IDLE});
    chk("abandon_stall", {31'h0, StallM}, 32'h0);
    chk("abandon_req", {31'h0, mem_req}, 32'h0);
    chk("abandon_rdata", ReadDataM, 32'h0);
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(negedge clk);
    chk("abandon_state2", {30'h0, dbg_state}, {30'h0, IDLE});
    @(posedge clk); #1;

    // Misaligned LW at 0x101.
`ifdef MEM_MISALIGN_TRAP_EN
    MemReadM = 1'b1; MemWriteM = 1'b0; funct3M = F3_LW; ALUResultM = 32'h101;
    mem_ready = 1'b1;
    @(negedge clk);
    chk("mis_flag", {31'h0, MisalignM}, 32'h1);
    chk("mis_req", {31'h0, mem_req}, 32'h0);
    chk("mis_stall", {31'h0, StallM}, 32'h0);
    chk("mis_rdata", ReadDataM, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mis_state", {30'h0, dbg_state}, {30'h0, IDLE});
    @(posedge clk); #1;
    mem_ready = 1'b0;
`else
    MemReadM = 1'b1; MemWriteM = 1'b0; funct3M = F3_LW; ALUResultM = 32'h101;
    @(negedge clk);
    chk("mis_flag", {31'h0, MisalignM}, 32'h0);
    @(posedge clk); #1;
    run_txn(mk(0, F3_LW, 32'h101, 0, 32'h0BAD_F00D, 0, 32'h0BAD_F00D, 0, 0));
`endif
    idle_cycles(1);

    // Random loads/stores against the model.
    for (int n = 0; n < 60; n++) begin
      int sel;
      logic [2:0] f3;
      logic [31:0] addr;
      v.st = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 4);
      if (v.st) f3 = (sel < 2) ? F3_SB : (sel < 4) ? F3_SH : F3_SW;
      else      f3 = (sel == 0) ? F3_LB : (sel == 1) ? F3_LH : (sel == 2) ? F3_LW :
                     (sel == 3) ? F3_LBU : F3_LHU;
      addr = $urandom;
`ifdef MEM_MISALIGN_TRAP_EN
      if (f3[1:0] == 2'b01) addr[0] = 1'b0;
      if (f3[1:0] == 2'b10) addr[1:0] = 2'b00;
`endif
      v.f3 = f3; v.addr = addr;
      v.wd = $urandom; v.rd = $urandom;
      v.waits = $urandom_range(0, 3);
      v.exp_rd   = model_load(f3, addr, v.rd);
      v.exp_strb = model_strb(f3, addr);
      v.exp_wd   = model_wdata(f3, v.wd);
      run_txn(v);
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2));
    end
    idle_cycles(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage data access unit of the pipelined RV32I core, sitting between the EX/MEM pipeline register and `mem_wb_reg`. It converts a load/store from the MEM stage into a request on a word-wide data-memory bus with a ready handshake, and stalls the pipeline while the access is outstanding. It produces the byte/halfword-aligned, sign- or zero-extended `ReadDataM` that `mem_wb_reg` captures. It also generates store byte strobes and lane-replicated write data.

## Interface
- `ADDR_W`, default 32: data-memory byte-address width.
- `clk` input 1: pipeline clock.
- `rst` input 1: reset. One clock domain; reset is synchronous and active-high.
- `ALUResultM` input 32: effective byte address.
- `WriteDataM` input 32: store source register value.
- `MemReadM` input 1: load in MEM.
- `MemWriteM` input 1: store in MEM.
- `funct3M` input 3: access size and sign.
- `ReadDataM` output 32: extended load data, to `mem_wb_reg`.
- `StallM` output 1: freezes PC, IF/ID, ID/EX and EX/MEM, and holds the MEM/WB input.
- `MisalignM` output 1: misaligned access flag (`MEM_MISALIGN_TRAP_EN` only; otherwise tied 0).
- `mem_req` output 1: bus request.
- `mem_we` output 1: write request.
- `mem_addr` output ADDR_W: word-aligned address, bits [1:0]=0.
- `mem_wstrb` output 4: byte strobes.
- `mem_wdata` output 32: replicated store data.
- `mem_rdata` input 32: read word.
- `mem_ready` input 1: access completes this cycle.

## Operation
- States are `IDLE`, `WAIT` and `DONE`.
- **IDLE**
  - With no access (`MemReadM`=`MemWriteM`=0): `mem_req`=0, `StallM`=0, `ReadDataM`=0.
  - With an access: `mem_req`=1 combinationally and `StallM`=1.
    - If `mem_ready`=1 in the same cycle, go to `DONE`.
    - Otherwise go to `WAIT`.
- **WAIT**: hold `mem_req` and all bus outputs stable, with `StallM`=1. When `mem_ready`=1, go to `DONE`.
- Capture: on the completing cycle, `mem_rdata` is registered into the internal `rdata_q`.
- **DONE**
  - `mem_req`=0 and `StallM`=0.
  - `ReadDataM` is the extension of `rdata_q`.
  - Next state is `IDLE` unconditionally.
  - The pipeline advances on this cycle, so the next instruction sees `IDLE` fresh. Back-to-back accesses never reuse `rdata_q`.
- Upstream holds `ALUResultM`, `WriteDataM`, `MemReadM`, `MemWriteM` and `funct3M` stable while `StallM`=1. The unit does not re-latch them.
- Loads, where `off`=`ALUResultM[1:0]`:
  - LB (000): sign-extend byte `off`.
  - LH (001): sign-extend half `off[1]`.
  - LW (010): full word.
  - LBU (100): zero-extend byte `off`.
  - LHU (101): zero-extend half `off[1]`.
  - Other funct3: the full word is returned.
- Stores:
  - SB: `mem_wstrb`=4'b0001<<`off`, `mem_wdata`={4{byte}}.
  - SH: `mem_wstrb`=4'b0011<<{`off[1]`,1'b0}, `mem_wdata`={2{half}}.
  - SW: `mem_wstrb`=4'b1111.
  - `mem_wstrb`=0 on loads and when `mem_req`=0.
- A store in `DONE` yields `ReadDataM`=0.
- If `MemReadM` and `MemWriteM` are both set, the access is treated as a store.
- `mem_ready` is ignored when `mem_req`=0.

## Timing
- Reset values: state=`IDLE`, `rdata_q`=0. All outputs are 0 during the reset cycle, overriding inputs.
- Reset mid-`WAIT`: the transaction is abandoned and the unit is in `IDLE` next cycle. A late `mem_ready` after that is ignored.
- Zero-wait memory (`mem_ready`=1 at issue): 1 stall cycle, then `DONE`.
- N wait cycles: N+1 stall cycles, then `DONE`.
- `ReadDataM` is valid only in the `DONE` cycle, which is when the pipeline register captures it.
- No timeout: `WAIT` persists indefinitely without `mem_ready`.

## Configuration
- Macro: `MEM_MISALIGN_TRAP_EN`.
- When defined:
  - A misaligned access (LH/LHU/SH with `off[0]`=1, or LW/SW with `off`≠0) issues no bus request and asserts no stall.
  - `MisalignM`=1 combinationally for that cycle.
  - `ReadDataM`=0.
  - The state stays `IDLE`.
- When undefined:
  - `MisalignM` is tied 0.
  - Address low bits select lanes as above: a half uses `off[1]`, a word ignores `off`.
  - The access proceeds normally.

## Structure
- Package `mem_pkg`:
  - funct3 localparams (`F3_LB`…`F3_LHU`).
  - `mem_state_t` enum {`IDLE`, `WAIT`, `DONE`}.
- Sub-module `load_extend`: purely combinational word + `off` + funct3 → 32-bit extended result.
- Store-strobe logic is local.

## Test plan
- LW at 0x100, `mem_ready` at issue, `mem_rdata`=0xDEADBEEF → `StallM` high for 1 cycle, `DONE` with `ReadDataM`=0xDEADBEEF.
- LB at 0x103, `mem_rdata`=0x80112233, 2 wait cycles → 3 stall cycles, `ReadDataM`=0xFFFFFF80. LBU gives 0x00000080.
- SH at 0x102 with `WriteDataM`=0x0000ABCD → `mem_we`=1, `mem_wstrb`=4'b1100, `mem_wdata`=0xABCDABCD, `mem_addr`=0x100.
- `rst` asserted during `WAIT`, then `mem_ready` pulsed next cycle → `StallM`=0, `mem_req`=0, state `IDLE`, `ReadDataM`=0.
- Back-to-back LW 0x0 (rdata 0x11111111) then LW 0x4 (rdata 0x22222222) → each `DONE` presents its own value and the second access issues a fresh request.
- With `MEM_MISALIGN_TRAP_EN`, LW at 0x101 → `MisalignM`=1, `mem_req`=0, `StallM`=0. Without the macro, the same access requests word address 0x100.
